wh_switch_allocator: RTL

WH_SWITCH_ALLOCATOR -- requirements
Module: wh_switch_allocator

---
 rtl/wh_switch_allocator.sv | 107 ++++++++++
 1 files changed

// File: rtl/wh_switch_allocator.sv
// wh_switch_allocator: wormhole switch allocator with per-output round-robin arbitration,
// packet locking from head to tail flit, and credit-based downstream flow control.
module wh_switch_allocator #(
    parameter int NUM_PORTS    = 5,
    parameter int CREDIT_DEPTH = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_PORTS-1:0]                     req,
    input  logic [NUM_PORTS*$clog2(NUM_PORTS+1)-1:0] route,
    input  logic [NUM_PORTS-1:0]                     tail,
    input  logic [NUM_PORTS-1:0]                     credit_return,
    output logic [NUM_PORTS-1:0]                     grant,
    output logic [NUM_PORTS*$clog2(NUM_PORTS+1)-1:0] out_select,
    output logic [NUM_PORTS-1:0]                     out_busy,
    output logic                                     route_err,
    output logic                                     credit_err
);
    localparam int SEL_W = $clog2(NUM_PORTS + 1);
    localparam int CW    = $clog2(CREDIT_DEPTH + 1);
    localparam logic [SEL_W-1:0] IDLE      = '1;
    localparam logic [SEL_W-1:0] LAST_INIT = SEL_W'(NUM_PORTS - 1);
    localparam logic [CW-1:0]    FULL      = CW'(CREDIT_DEPTH);

    logic [SEL_W-1:0]     sel [NUM_PORTS];
    logic [NUM_PORTS-1:0] cerr;
    logic                 bad_route;

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic                 lock;
        logic [SEL_W-1:0]     holder;
        logic [SEL_W-1:0]     last_grant;
        logic [CW-1:0]        credit;
        logic                 ce;
        logic [NUM_PORTS-1:0] r;
        logic [SEL_W-1:0]     pick;
        logic [SEL_W-1:0]     idx;
        logic                 g;
        logic                 win_tail;
        // Scan from farthest to nearest so the first requester after last_grant wins.
        always_comb begin
            r    = '0;
            pick = IDLE;
            idx  = '0;
            for (int i = 0; i < NUM_PORTS; i++)
                r[i] = req[i] && (route[i*SEL_W +: SEL_W] == SEL_W'(o));
            for (int k = NUM_PORTS; k >= 1; k--) begin
                idx = SEL_W'((int'(last_grant) + k) % NUM_PORTS);
                if (r[idx]) pick = idx;
            end
        end
        assign sel[o] = (!rst_n || credit == '0) ? IDLE :
                        lock ? (r[holder] ? holder : IDLE) : pick;
        assign g        = sel[o] != IDLE;
        assign win_tail = g && tail[sel[o]];
        assign out_select[o*SEL_W +: SEL_W] = sel[o];
        assign out_busy[o] = lock;
        assign cerr[o]     = ce;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lock       <= 1'b0;
                holder     <= '0;
                last_grant <= LAST_INIT;
                credit     <= FULL;
                ce         <= 1'b0;
            end else begin
                if (g && !lock) begin
                    last_grant <= sel[o];
                    if (!win_tail) begin
                        lock   <= 1'b1;
                        holder <= sel[o];
                    end
                end
                if (g && lock && win_tail) begin
                    lock       <= 1'b0;
                    last_grant <= holder;
                end
                if (g && !credit_return[o])
                    credit <= credit - CW'(1);
                else if (!g && credit_return[o]) begin
                    if (credit == FULL) ce <= 1'b1;
                    else credit <= credit + CW'(1);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int o = 0; o < NUM_PORTS; o++)
            for (int i = 0; i < NUM_PORTS; i++)
                if (sel[o] == SEL_W'(i)) grant[i] = 1'b1;
    end

    always_comb begin
        bad_route = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++)
            bad_route = bad_route | (req[i] && (route[i*SEL_W +: SEL_W] >= SEL_W'(NUM_PORTS)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) route_err <= 1'b0;
        else if (bad_route) route_err <= 1'b1;
    end

    assign credit_err = |cerr;
endmodule
